pic_fetch_unit: RTL and testbench

// - Instruction fetch stage feeding the core: owns PC, the 4-clock Q-cycle sequencer, the
//   8-level hardware return stack and the instruction register (IR). Drives the synchronous

---
 rtl/pic_fetch_unit_pkg.sv | 38 +++
 rtl/pic_fetch_unit_if.sv | 21 ++
 rtl/pic_fetch_unit_hw_stack.sv | 52 +++++
 rtl/pic_fetch_unit.sv | 111 +++++++++++
 tb/tb_pic_fetch_unit.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/pic_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// pic_fetch_unit_pkg
// Shared definitions for the PIC instruction fetch stage: PC operation
// encodings driven by execute, Q-phase names, the NOP word and the reset and
// interrupt vectors, plus a helper that says which PC operations discard the
// prefetched word.
// -----------------------------------------------------------------------------
package pic_fetch_unit_pkg;

  typedef enum logic [2:0] {
    PC_OP_INC    = 3'd0,
    PC_OP_GOTO   = 3'd1,
    PC_OP_CALL   = 3'd2,
    PC_OP_RETURN = 3'd3,
    PC_OP_PCLWR  = 3'd4,
    PC_OP_SKIP   = 3'd5,
    PC_OP_INT    = 3'd6,
    PC_OP_RSVD   = 3'd7
  } pc_op_e;

  typedef enum logic [1:0] {
    Q1 = 2'd0,
    Q2 = 2'd1,
    Q3 = 2'd2,
    Q4 = 2'd3
  } q_phase_e;

  localparam logic [13:0] NOP_INSTR    = 14'h0000;
  localparam logic [12:0] RESET_VECTOR = 13'h0000;
  localparam logic [12:0] INT_VECTOR   = 13'h0004;

  // Every operation except a plain increment (and the reserved code, which
  // behaves as one) invalidates the word prefetched during this cycle.
  function automatic logic op_flushes(input pc_op_e op);
    return !((op == PC_OP_INC) || (op == PC_OP_RSVD));
  endfunction

endpackage

// File: rtl/pic_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// pic_fetch_unit_if
// Program-memory bus between the fetch unit (master) and a synchronous
// program memory with one clock of read latency (slave).
//   pm_rd_en  master->slave  read strobe
//   pm_addr   master->slave  word address
//   pm_instr  slave->master  read data, valid the clock after pm_rd_en
// -----------------------------------------------------------------------------
interface pic_fetch_unit_if #(
  parameter int ADDR_WIDTH  = 13,
  parameter int INSTR_WIDTH = 14
);

  logic                   pm_rd_en;
  logic [ADDR_WIDTH-1:0]  pm_addr;
  logic [INSTR_WIDTH-1:0] pm_instr;

  modport master (output pm_rd_en, output pm_addr, input pm_instr);
  modport slave  (input pm_rd_en, input pm_addr, output pm_instr);

endinterface

// File: rtl/pic_fetch_unit_hw_stack.sv
// -----------------------------------------------------------------------------
// pic_fetch_unit_hw_stack
// Circular hardware return stack without overflow/underflow flags. A push
// writes entry[sp] then increments sp; a pop decrements sp. The pointer wraps,
// so a ninth push overwrites the oldest entry and a pop on an empty stack
// returns whatever the wrapped pointer addresses. Reset clears sp only.
//   clk, rst_n   clock, asynchronous active-low reset
//   push, pop    one-cycle strobes (never both at once)
//   push_data    return address to save
//   top          entry[sp-1], the address a pop returns
// -----------------------------------------------------------------------------
module pic_fetch_unit_hw_stack #(
  parameter int ADDR_WIDTH  = 13,
  parameter int STACK_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [ADDR_WIDTH-1:0] push_data,
  output logic [ADDR_WIDTH-1:0] top
);

  localparam int SP_W = $clog2(STACK_DEPTH);
  localparam logic [SP_W-1:0] SP_ONE = SP_W'(1);

  logic [SP_W-1:0]       sp;
  logic [SP_W-1:0]       sp_dec;
  logic [ADDR_WIDTH-1:0] entry [STACK_DEPTH];

  // Depth is a power of two, so natural pointer overflow gives the wrap.
  assign sp_dec = sp - SP_ONE;
  assign top    = entry[sp_dec];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp <= '0;
    end else if (push) begin
      sp <= sp + SP_ONE;
    end else if (pop) begin
      sp <= sp_dec;
    end
  end

  // Contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (push) begin
      entry[sp] <= push_data;
    end
  end

endmodule

// File: rtl/pic_fetch_unit.sv
// -----------------------------------------------------------------------------
// pic_fetch_unit
// Two-stage PIC fetch: owns the Q1..Q4 sequencer, PC, instruction register and
// return stack. The word at PC is read in Q1, captured at the end of Q2 and
// moved into IR at the end of Q4, while the PC update chosen by execute is
// applied on that same edge. Redirects replace the prefetched word by a NOP.
//   clk, rst_n  clock, asynchronous active-low reset
//   stall       freezes every register; suppresses the memory read
//   pc_op       PC operation, sampled only at the Q4 edge
//   jmp_k       GOTO/CALL literal
//   pclath      PCLATH value (upper address bits)
//   pcl_wdata   new PCL value for a PCL write
//   pm          program-memory bus (master side)
//   ir          instruction register to decode
//   q_phase     0..3 = Q1..Q4
//   cycle_end   high during Q4
//   pc          prefetch address (executing address + 1)
// -----------------------------------------------------------------------------
module pic_fetch_unit
  import pic_fetch_unit_pkg::*;
#(
  parameter int ADDR_WIDTH  = 13,
  parameter int INSTR_WIDTH = 14,
  parameter int STACK_DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stall,
  input  logic [2:0]             pc_op,
  input  logic [10:0]            jmp_k,
  input  logic [4:0]             pclath,
  input  logic [7:0]             pcl_wdata,
  pic_fetch_unit_if.master       pm,
  output logic [INSTR_WIDTH-1:0] ir,
  output logic [1:0]             q_phase,
  output logic                   cycle_end,
  output logic [ADDR_WIDTH-1:0]  pc
);

  localparam logic [ADDR_WIDTH-1:0] PC_ONE = ADDR_WIDTH'(1);

  q_phase_e               q_reg;
  logic [ADDR_WIDTH-1:0]  pc_reg;
  logic [INSTR_WIDTH-1:0] ir_reg;
  logic [INSTR_WIDTH-1:0] fetch_buf_reg;

  pc_op_e                 op;
  logic                   commit;
  logic                   push;
  logic                   pop;
  logic [ADDR_WIDTH-1:0]  stack_top;
  logic [ADDR_WIDTH-1:0]  pc_next;

  assign op     = pc_op_e'(pc_op);
  // The Q4 edge only counts when it actually advances the sequencer.
  assign commit = (q_reg == Q4) && !stall;
  assign push   = commit && ((op == PC_OP_CALL) || (op == PC_OP_INT));
  assign pop    = commit && (op == PC_OP_RETURN);

  always_comb begin
    pc_next = pc_reg + PC_ONE;
    case (op)
      PC_OP_GOTO,
      PC_OP_CALL:   pc_next = ADDR_WIDTH'({pclath[4:3], jmp_k});
      PC_OP_RETURN: pc_next = stack_top;
      PC_OP_PCLWR:  pc_next = ADDR_WIDTH'({pclath, pcl_wdata});
      PC_OP_INT:    pc_next = ADDR_WIDTH'(INT_VECTOR);
      default:      ;
    endcase
  end

  pic_fetch_unit_hw_stack #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .push_data (pc_reg),
    .top       (stack_top)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg         <= Q1;
      pc_reg        <= ADDR_WIDTH'(RESET_VECTOR);
      ir_reg        <= INSTR_WIDTH'(NOP_INSTR);
      fetch_buf_reg <= INSTR_WIDTH'(NOP_INSTR);
    end else if (!stall) begin
      q_reg <= q_phase_e'(q_reg + 2'd1);
      if (q_reg == Q2) begin
        fetch_buf_reg <= pm.pm_instr;
      end
      if (q_reg == Q4) begin
        ir_reg <= op_flushes(op) ? INSTR_WIDTH'(NOP_INSTR) : fetch_buf_reg;
        pc_reg <= pc_next;
      end
    end
  end

  // Read strobe is gated by reset so nothing is fetched while held in reset.
  assign pm.pm_rd_en = rst_n && (q_reg == Q1) && !stall;
  assign pm.pm_addr  = pc_reg;

  assign ir        = ir_reg;
  assign q_phase   = q_reg;
  assign cycle_end = (q_reg == Q4);
  assign pc        = pc_reg;

endmodule

// File: tb/tb_pic_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_pic_fetch_unit
// Drives directed instruction cycles into pic_fetch_unit with a synchronous
// program memory whose word at address a is 0x2000|a. An instruction-level
// model tracks phase, PC, IR and the return stack; a compare process checks
// every output against it each cycle, and literal checks pin the model.
// -----------------------------------------------------------------------------
module tb_pic_fetch_unit;
  import pic_fetch_unit_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic [2:0]  pc_op;
  logic [10:0] jmp_k;
  logic [4:0]  pclath;
  logic [7:0]  pcl_wdata;
  logic [13:0] ir;
  logic [1:0]  q_phase;
  logic        cycle_end;
  logic [12:0] pc;

  pic_fetch_unit_if #(.ADDR_WIDTH(13), .INSTR_WIDTH(14)) pm ();

  pic_fetch_unit #(
    .ADDR_WIDTH  (13),
    .INSTR_WIDTH (14),
    .STACK_DEPTH (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall     (stall),
    .pc_op     (pc_op),
    .jmp_k     (jmp_k),
    .pclath    (pclath),
    .pcl_wdata (pcl_wdata),
    .pm        (pm),
    .ir        (ir),
    .q_phase   (q_phase),
    .cycle_end (cycle_end),
    .pc        (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program memory: one clock read latency.
  logic [13:0] mem [8192];
  always @(posedge clk) begin
    if (pm.pm_rd_en) pm.pm_instr <= mem[pm.pm_addr];
  end

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction-level model: IR takes the word at PC directly from memory.
  logic [1:0]  m_q;
  logic [12:0] m_pc;
  logic [13:0] m_ir;
  logic [12:0] m_stack [8];
  logic [2:0]  m_sp;
  logic [12:0] m_npc;
  logic        m_flush;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q  = 2'd0;
      m_pc = 13'h0000;
      m_ir = 14'h0000;
      m_sp = 3'd0;
    end else if (!stall) begin
      if (m_q == 2'd3) begin
        m_npc   = m_pc + 13'd1;
        m_flush = 1'b1;
        case (pc_op)
          PC_OP_GOTO:   m_npc = {pclath[4:3], jmp_k};
          PC_OP_CALL:   begin
            m_stack[m_sp] = m_pc;
            m_sp = m_sp + 3'd1;
            m_npc = {pclath[4:3], jmp_k};
          end
          PC_OP_RETURN: begin
            m_sp = m_sp - 3'd1;
            m_npc = m_stack[m_sp];
          end
          PC_OP_PCLWR:  m_npc = {pclath, pcl_wdata};
          PC_OP_SKIP:   ;
          PC_OP_INT:    begin
            m_stack[m_sp] = m_pc;
            m_sp = m_sp + 3'd1;
            m_npc = 13'h0004;
          end
          default:      m_flush = 1'b0;
        endcase
        m_ir = m_flush ? 14'h0000 : mem[m_pc];
        m_pc = m_npc;
      end
      m_q = m_q + 2'd1;
    end
  end

  // Compare process: every cycle, on the falling edge.
  always @(negedge clk) begin
    chk("q_phase",   32'(q_phase),     32'(m_q));
    chk("pc",        32'(pc),          32'(m_pc));
    chk("ir",        32'(ir),          32'(m_ir));
    chk("cycle_end", 32'(cycle_end),   32'(m_q == 2'd3));
    chk("pm_rd_en",  32'(pm.pm_rd_en), 32'(rst_n && (m_q == 2'd0) && !stall));
    chk("pm_addr",   32'(pm.pm_addr),  32'(m_pc));
  end

  // One instruction cycle; pc_op is only meaningful in Q4, so other phases
  // carry random junk. Optionally stalls for stall_len clocks in phase stall_q.
  task automatic do_cycle(input logic [2:0] op, input logic [10:0] k,
                          input logic [4:0] lath, input logic [7:0] pcl,
                          input int stall_q = -1, input int stall_len = 0);
    bit done = 1'b0;
    bit stalled = 1'b0;
    while (!done) begin
      @(negedge clk); #1;
      if (m_q == 2'd3) begin
        pc_op = op; jmp_k = k; pclath = lath; pcl_wdata = pcl;
        done = 1'b1;
      end else begin
        pc_op = 3'($urandom); jmp_k = 11'($urandom);
        pclath = 5'($urandom); pcl_wdata = 8'($urandom);
      end
      if (!stalled && stall_len > 0 && int'(m_q) == stall_q) begin
        stalled = 1'b1;
        stall = 1'b1;
        repeat (stall_len) begin @(negedge clk); #1; end
        stall = 1'b0;
      end
    end
    @(posedge clk); #1;
    $display("cycle op=%0d pc=%04h ir=%04h", op, pc, ir);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 8192; a++) mem[a] = 14'h2000 | 14'(a);
    rst_n = 1'b0; stall = 1'b0; pc_op = 3'd0; jmp_k = '0; pclath = '0; pcl_wdata = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_q",     32'(q_phase),     32'h0);
    chk("rst_pc",    32'(pc),          32'h0);
    chk("rst_ir",    32'(ir),          32'h0);
    chk("rst_rd_en", 32'(pm.pm_rd_en), 32'h0);
    rst_n = 1'b1;

    // Sequential fetch.
    do_cycle(PC_OP_INC, 0, 0, 0);
    chk("inc0_ir", 32'(ir), 32'h2000); chk("inc0_pc", 32'(pc), 32'h0001);
    do_cycle(PC_OP_INC, 0, 0, 0);
    chk("inc1_ir", 32'(ir), 32'h2001); chk("inc1_pc", 32'(pc), 32'h0002);

    // GOTO with PCLATH upper bits.
    do_cycle(PC_OP_GOTO, 11'h123, 5'b11000, 0);
    chk("goto_ir", 32'(ir), 32'h0000); chk("goto_pc", 32'(pc), 32'h1923);
    do_cycle(PC_OP_INC, 0, 0, 0);
    chk("goto_ir2", 32'(ir), 32'h3923); chk("goto_pc2", 32'(pc), 32'h1924);

    // Nine calls wrap the stack, nine returns.
    for (int i = 0; i < 9; i++) do_cycle(PC_OP_CALL, 11'(11'h100 + i * 16), 5'd0, 0);
    for (int i = 0; i < 9; i++) begin
      do_cycle(PC_OP_RETURN, 0, 0, 0);
      if (i == 0) chk("ret1_pc", 32'(pc), 32'h0170);
      if (i == 7) chk("ret8_pc", 32'(pc), 32'h0100);
      if (i == 8) chk("ret9_pc", 32'(pc), 32'h0170);
    end

    // PCL write, then SKIP.
    do_cycle(PC_OP_PCLWR, 0, 5'h02, 8'hFF);
    chk("pclwr_pc", 32'(pc), 32'h02FF);
    do_cycle(PC_OP_INC, 0, 0, 0);
    chk("pclwr_ir", 32'(ir), 32'h22FF);
    do_cycle(PC_OP_SKIP, 0, 0, 0);
    chk("skip_ir", 32'(ir), 32'h0000);
    do_cycle(PC_OP_INC, 0, 0, 0);
    chk("skip_ir2", 32'(ir), 32'h2301);

    // Interrupt while executing 0x0010.
    do_cycle(PC_OP_GOTO, 11'h00F, 5'd0, 0);
    do_cycle(PC_OP_INC, 0, 0, 0);
    do_cycle(PC_OP_INC, 0, 0, 0);
    chk("pre_int_ir", 32'(ir), 32'h2010);
    do_cycle(PC_OP_INT, 0, 0, 0);
    chk("int_pc", 32'(pc), 32'h0004); chk("int_ir", 32'(ir), 32'h0000);
    do_cycle(PC_OP_INC, 0, 0, 0);
    chk("isr_ir", 32'(ir), 32'h2004);
    do_cycle(PC_OP_RETURN, 0, 0, 0);
    chk("retfie_pc", 32'(pc), 32'h0011);

    // Stalls in Q3, Q1 and Q4; PC wrap; reserved op.
    do_cycle(PC_OP_INC, 0, 0, 0, 2, 10);
    do_cycle(PC_OP_INC, 0, 0, 0, 0, 3);
    do_cycle(PC_OP_GOTO, 11'h7FF, 5'b11000, 0, 3, 3);
    chk("goto_top_pc", 32'(pc), 32'h1FFF);
    do_cycle(PC_OP_INC, 0, 0, 0);
    chk("wrap_pc", 32'(pc), 32'h0000); chk("wrap_ir", 32'(ir), 32'h3FFF);
    do_cycle(PC_OP_RSVD, 0, 0, 0);
    chk("rsvd_pc", 32'(pc), 32'h0001); chk("rsvd_ir", 32'(ir), 32'h2000);

    // Reset asserted in Q2.
    do begin @(negedge clk); #1; end while (m_q != 2'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ir", 32'(ir), 32'h0);
    chk("mid_rst_pc", 32'(pc), 32'h0);
    chk("mid_rst_q",  32'(q_phase), 32'h0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    do_cycle(PC_OP_INC, 0, 0, 0);
    chk("post_rst_ir", 32'(ir), 32'h2000); chk("post_rst_pc", 32'(pc), 32'h0001);

    @(negedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
